riscboy_ppu_busarb: RTL and testbench

- Shares one AHB-Lite read-only master port between N_REQ PPU fetch engines (backgrounds, sprites).
- Each engine uses the PPU single-handshake bus: it holds vld/addr/size until rdy, and rdy coincides with valid read data.
- The block converts these requests into pipelined AHB-Lite transfers, with round-robin arbitration and one transfer in data phase at a time.
- Sits between the PPU engines and the system bus fabric.

---
 rtl/riscboy_ppu_busarb_pkg.sv | 14 +
 rtl/riscboy_ppu_busarb_if.sv | 40 ++++
 rtl/riscboy_ppu_rr_arbiter.sv | 31 +++
 rtl/riscboy_ppu_busarb.sv | 91 +++++++++
 tb/tb_riscboy_ppu_busarb.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/riscboy_ppu_busarb_pkg.sv
// Shared constants for the PPU bus arbiter: AHB transfer encodings and index sizing.
package riscboy_ppu_busarb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_NONSEQ = 2'b10
   } htrans_t;

   // Index width that stays at least one bit wide for a single requester.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/riscboy_ppu_busarb_if.sv
// Bundle of PPU engine request signals and the AHB-Lite read master port.
interface riscboy_ppu_busarb_if #(
   parameter int N_REQ  = 4,
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
);

   // Engine side: src_vld[i] with its addr/size is held until src_rdy[i]; src_rdy[i]
   // is the single cycle where src_data is valid for that engine, and a new
   // request may already be presented in that cycle.
   logic [N_REQ-1:0]        src_vld;
   logic [N_REQ*W_ADDR-1:0] src_addr;
   logic [2*N_REQ-1:0]      src_size;
   logic [N_REQ-1:0]        src_rdy;
   logic [W_DATA-1:0]       src_data;

   logic [W_ADDR-1:0]       ahblm_haddr;
   logic [1:0]              ahblm_htrans;
   logic                    ahblm_hwrite;
   logic [2:0]              ahblm_hsize;
   logic                    ahblm_hready;
   logic                    ahblm_hresp;
   logic [W_DATA-1:0]       ahblm_hrdata;

   // master: the arbiter, which masters the AHB port and answers the engines
   modport master (
      input  src_vld, src_addr, src_size,
      output src_rdy, src_data,
      output ahblm_haddr, ahblm_htrans, ahblm_hwrite, ahblm_hsize,
      input  ahblm_hready, ahblm_hresp, ahblm_hrdata
   );

   modport slave (
      output src_vld, src_addr, src_size,
      input  src_rdy, src_data,
      input  ahblm_haddr, ahblm_htrans, ahblm_hwrite, ahblm_hsize,
      output ahblm_hready, ahblm_hresp, ahblm_hrdata
   );

endinterface

// File: rtl/riscboy_ppu_rr_arbiter.sv
// Combinational round-robin select: first set request at or above ptr, wrapping.
module riscboy_ppu_rr_arbiter
   import riscboy_ppu_busarb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int W_IDX = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [W_IDX-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [W_IDX-1:0] idx
);

   int j;

   // Scan from lowest to highest priority so the last hit is the winner.
   always_comb begin
      gnt = '0;
      idx = '0;
      j   = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % N_REQ;
         if (req[j]) begin
            gnt    = '0;
            gnt[j] = 1'b1;
            idx    = W_IDX'(j);
         end
      end
   end

endmodule

// File: rtl/riscboy_ppu_busarb.sv
// Shares one AHB-Lite read master between PPU fetch engines, round-robin, one data phase open.
module riscboy_ppu_busarb
   import riscboy_ppu_busarb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int W_ADDR    = 32,
   parameter int W_DATA    = 32,
   parameter int W_REQ_IDX = idx_w(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   riscboy_ppu_busarb_if.master bus,
   output logic                 err_sticky
);

   logic                 dph_vld;
   logic [W_REQ_IDX-1:0] dph_owner;
   logic                 aph_held;
   logic [W_REQ_IDX-1:0] aph_owner;
   logic [W_REQ_IDX-1:0] rr_ptr;

   logic [N_REQ-1:0]     dph_mask;
   logic [N_REQ-1:0]     eligible;
   logic [N_REQ-1:0]     arb_gnt;
   logic [W_REQ_IDX-1:0] arb_idx;
   logic [W_REQ_IDX-1:0] grant;
   logic [W_REQ_IDX-1:0] rr_next;
   logic                 nonseq;
   logic [W_DATA-1:0]    rdata;

   always_comb begin
      dph_mask = '0;
      if (dph_vld) dph_mask[dph_owner] = 1'b1;
   end

   // The owner of the open data phase sits out, so a fresh request issued in its
   // rdy cycle is only arbitrated from the following cycle.
   assign eligible = bus.src_vld & ~dph_mask;

   riscboy_ppu_rr_arbiter #(
      .N_REQ (N_REQ),
      .W_IDX (W_REQ_IDX)
   ) u_arb (
      .req (eligible),
      .ptr (rr_ptr),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   // A stalled address phase must be replayed unchanged until hready.
   assign grant   = aph_held ? aph_owner : arb_idx;
   assign nonseq  = aph_held || (|arb_gnt);
   assign rr_next = (int'(grant) == N_REQ - 1) ? '0 : grant + 1'b1;

   always_comb begin
      bus.ahblm_htrans = HTRANS_IDLE;
      bus.ahblm_haddr  = '0;
      bus.ahblm_hsize  = '0;
      if (nonseq) begin
         bus.ahblm_htrans = HTRANS_NONSEQ;
         bus.ahblm_haddr  = bus.src_addr[int'(grant) * W_ADDR +: W_ADDR];
         bus.ahblm_hsize  = {1'b0, bus.src_size[int'(grant) * 2 +: 2]};
      end
   end

   assign bus.ahblm_hwrite = 1'b0;
   assign rdata            = bus.ahblm_hrdata;
   assign bus.src_data     = rdata;
   assign bus.src_rdy      = bus.ahblm_hready ? dph_mask : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dph_vld    <= 1'b0;
         dph_owner  <= '0;
         aph_held   <= 1'b0;
         aph_owner  <= '0;
         rr_ptr     <= '0;
         err_sticky <= 1'b0;
      end else if (bus.ahblm_hready) begin
         dph_vld   <= nonseq;
         dph_owner <= grant;
         aph_held  <= 1'b0;
         if (nonseq) rr_ptr <= rr_next;
         if (dph_vld && bus.ahblm_hresp) err_sticky <= 1'b1;
      end else if (nonseq && !aph_held) begin
         aph_held  <= 1'b1;
         aph_owner <= grant;
      end
   end

endmodule

// File: tb/tb_riscboy_ppu_busarb.sv
// Bench for riscboy_ppu_busarb: directed scenarios plus random traffic against a reference model.
module tb_riscboy_ppu_busarb;

   localparam int N  = 4;
   localparam int WA = 32;
   localparam int WD = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   riscboy_ppu_busarb_if #(.N_REQ(N), .W_ADDR(WA), .W_DATA(WD)) bus ();
   logic err_sticky;

   riscboy_ppu_busarb #(.N_REQ(N), .W_ADDR(WA), .W_DATA(WD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .err_sticky (err_sticky)
   );

   logic [N-1:0]    vld;
   logic [WA-1:0]   addr [N];
   logic [1:0]      size [N];
   logic            hready;
   logic            hresp;
   logic [WD-1:0]   hrdata;

   assign bus.src_vld      = vld;
   assign bus.ahblm_hready = hready;
   assign bus.ahblm_hresp  = hresp;
   assign bus.ahblm_hrdata = hrdata;
   for (genvar g = 0; g < N; g++) begin : g_pack
      assign bus.src_addr[g*WA +: WA] = addr[g];
      assign bus.src_size[2*g +: 2]   = size[g];
   end

   int n_vec = 0;
   int n_err = 0;
   logic [N-1:0] done_mask = '0;
   logic [1:0]   exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: who owns the bus, in abstract integer terms (-1 = nobody).
   int   m_dph  = -1;
   int   m_held = -1;
   int   m_ptr  = 0;
   bit   m_err  = 1'b0;
   bit   m_live = 1'b0;
   int   own;
   int   jj;
   logic [63:0] exp_rdy;
   logic [2:0]  exp_size;
   logic [1:0]  popped;

   always @(negedge clk) begin
      done_mask = bus.src_rdy;
      if (!rst_n) begin
         m_dph  = -1;
         m_held = -1;
         m_ptr  = 0;
         m_err  = 1'b0;
         m_live = 1'b1;
         exp_q.delete();
      end else if (m_live) begin
         own = -1;
         if (m_held >= 0) own = m_held;
         else begin
            for (int k = 0; k < N; k++) begin
               jj = (m_ptr + k) % N;
               if (own < 0 && vld[jj] && jj != m_dph) own = jj;
            end
         end
         exp_size = (own >= 0) ? {1'b0, size[own]} : 3'd0;
         check("htrans", bus.ahblm_htrans, (own >= 0) ? 64'd2 : 64'd0);
         check("haddr", bus.ahblm_haddr, (own >= 0) ? addr[own] : '0);
         check("hsize", bus.ahblm_hsize, exp_size);
         check("hwrite", bus.ahblm_hwrite, 0);
         check("err_sticky", err_sticky, m_err);
         exp_rdy = (m_dph >= 0 && hready) ? (64'd1 << m_dph) : 64'd0;
         check("src_rdy", bus.src_rdy, exp_rdy);
         if (bus.src_rdy != '0) begin
            if (exp_q.size() == 0) check("rdy_unexpected", bus.src_rdy, 0);
            else begin
               popped = exp_q.pop_front();
               check("rdy_owner", bus.src_rdy, 64'd1 << popped);
               check("src_data", bus.src_data, hrdata);
            end
         end
         if (hready) begin
            if (m_dph >= 0 && hresp) m_err = 1'b1;
            if (own >= 0) begin
               exp_q.push_back(2'(own));
               m_ptr = (own + 1) % N;
            end
            m_dph  = own;
            m_held = -1;
         end else if (own >= 0 && m_held < 0) begin
            m_held = own;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (done_mask[i]) vld[i] = 1'b0;
   endtask

   task automatic issue(input int i, input logic [WA-1:0] a, input logic [1:0] s);
      vld[i]  = 1'b1;
      addr[i] = a;
      size[i] = s;
   endtask

   task automatic drain();
      hresp = 1'b0;
      for (int c = 0; c < 40 && vld != '0; c++) begin
         step();
         hready = 1'b1;
         hrdata = $urandom;
      end
      check("drain", vld, 0);
      step();
   endtask

   initial begin
      vld    = '0;
      hready = 1'b1;
      hresp  = 1'b0;
      hrdata = '0;
      for (int i = 0; i < N; i++) begin
         addr[i] = '0;
         size[i] = '0;
      end
      repeat (3) step();
      rst_n = 1'b1;

      // single request with no wait states
      step();
      issue(0, 32'h2000_0100, 2'd2);
      hrdata = $urandom;
      repeat (3) begin step(); hrdata = $urandom; end

      // all engines requesting continuously
      for (int c = 0; c < 24; c++) begin
         step();
         for (int i = 0; i < N; i++) if (!vld[i]) issue(i, $urandom, 2'($urandom_range(0, 2)));
         hready = 1'b1;
         hrdata = $urandom;
      end
      drain();

      // wait-state hold while another engine arrives mid-stall
      step(); issue(1, 32'h1000_0040, 2'd1); hready = 1'b0;
      step(); hready = 1'b0;
      step(); issue(0, 32'h1000_0080, 2'd2); hready = 1'b0;
      step(); hready = 1'b1; hrdata = $urandom;
      drain();

      // back-to-back pipelining
      step(); issue(2, 32'h3000_0000, 2'd2); issue(3, 32'h3000_0004, 2'd0); hready = 1'b1;
      drain();

      // two-cycle error response
      step(); issue(0, 32'h4000_0010, 2'd2); hready = 1'b1; hresp = 1'b0;
      step(); hready = 1'b0; hresp = 1'b1;
      step(); hready = 1'b1; hresp = 1'b1; hrdata = $urandom;
      step(); hresp = 1'b0;
      drain();
      repeat (2) step();

      // reset with a held address phase and an open data phase
      step(); issue(0, 32'h5000_0000, 2'd2); hready = 1'b1;
      step(); issue(1, 32'h5000_0100, 2'd2); hready = 1'b0;
      step(); rst_n = 1'b0; vld = '0; hready = 1'b0;
      step(); rst_n = 1'b1; hready = 1'b1;
      step(); issue(3, 32'h6000_0000, 2'd1); issue(0, 32'h6000_0008, 2'd1);
      drain();

      // random traffic
      for (int c = 0; c < 800; c++) begin
         step();
         for (int i = 0; i < N; i++)
            if (!vld[i] && $urandom_range(0, 99) < 40) issue(i, $urandom, 2'($urandom_range(0, 2)));
         hready = ($urandom_range(0, 99) < 70);
         hresp  = ($urandom_range(0, 19) == 0);
         hrdata = $urandom;
      end
      drain();
      check("exp_q_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
